// File: rtl/demux_4_reg.sv
// demux_4_reg: registered 1-to-4 demultiplexer with one holding register per channel.
// A single producer routes WIDTH-bit words to one of four consumers chosen by in_sel.
// Each consumer channel has its own valid/ready handshake.
// Ports:
//   clk, rst             clock; asynchronous active-high reset
//   in_valid/in_ready    producer handshake (in_ready is combinational from out_ready/in_sel)
//   in_sel, in_data      destination channel index and the word to route
//   out_valid[3:0]       per-channel holding-register valid
//   out_ready[3:0]       per-channel consumer take
//   out_data0..3         per-channel held word
//   busy                 any channel holds a word
module demux_4_reg #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_sel,
   input  logic [WIDTH-1:0] in_data,
   output logic [3:0]       out_valid,
   input  logic [3:0]       out_ready,
   output logic [WIDTH-1:0] out_data0,
   output logic [WIDTH-1:0] out_data1,
   output logic [WIDTH-1:0] out_data2,
   output logic [WIDTH-1:0] out_data3,
   output logic             busy
);

   localparam int unsigned NCH = 4;

   logic [NCH-1:0]            vld_q, vld_d;
   logic [NCH-1:0][WIDTH-1:0] dat_q, dat_d;
   logic                      busy_q, busy_d;
   logic                      accept;

   // Destination slot is free, or it is being drained this cycle (pass-through refill).
   assign in_ready = ~vld_q[in_sel] | out_ready[in_sel];
   assign accept   = in_valid & in_ready;

   // Next-state: drains clear valid first, an accept then overrides its own channel.
   always_comb begin
      vld_d = vld_q;
      dat_d = dat_q;
      for (int k = 0; k < NCH; k++) begin
         if (vld_q[k] & out_ready[k]) begin
            vld_d[k] = 1'b0;
         end
      end
      if (accept) begin
         vld_d[in_sel] = 1'b1;
         dat_d[in_sel] = in_data;
      end
      busy_d = |vld_d;
   end

   // State registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_q  <= '0;
         dat_q  <= '0;
         busy_q <= 1'b0;
      end else begin
         vld_q  <= vld_d;
         dat_q  <= dat_d;
         busy_q <= busy_d;
      end
   end

   assign out_valid = vld_q;
   assign out_data0 = dat_q[0];
   assign out_data1 = dat_q[1];
   assign out_data2 = dat_q[2];
   assign out_data3 = dat_q[3];
   assign busy      = busy_q;

endmodule

// File: tb/tb_demux_4_reg.sv
// tb_demux_4_reg: directed vectors plus a random phase, checked by a per-channel scoreboard.
module tb_demux_4_reg;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  in_sel;
   logic [31:0] in_data;
   logic [3:0]  out_valid;
   logic [3:0]  out_ready;
   logic [31:0] out_data0, out_data1, out_data2, out_data3;
   logic        busy;

   int ncmp = 0;
   int nerr = 0;

   logic [31:0] sb [4][$];

   demux_4_reg #(.WIDTH(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_sel    (in_sel),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data0 (out_data0),
      .out_data1 (out_data1),
      .out_data2 (out_data2),
      .out_data3 (out_data3),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      ncmp++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] dat_of(input int k);
      case (k)
         0: return out_data0;
         1: return out_data1;
         2: return out_data2;
         default: return out_data3;
      endcase
   endfunction

   // Monitor: model channel k as full iff its queue is non-empty; pop on drain, push on accept.
   always @(negedge clk) begin
      logic exp_ready;
      logic exp_busy;
      if (rst) begin
         for (int k = 0; k < 4; k++) sb[k].delete();
      end else begin
         exp_ready = (sb[in_sel].size() == 0) || out_ready[in_sel];
         chk("mon_in_ready", 32'(in_ready), 32'(exp_ready));
         exp_busy = 1'b0;
         for (int k = 0; k < 4; k++) begin
            exp_busy = exp_busy | (sb[k].size() != 0);
            chk("mon_out_valid", 32'(out_valid[k]), 32'(sb[k].size() != 0));
            if (sb[k].size() != 0) chk("mon_out_data", dat_of(k), sb[k][0]);
         end
         chk("mon_busy", 32'(busy), 32'(exp_busy));
         for (int k = 0; k < 4; k++) begin
            if (sb[k].size() != 0 && out_ready[k]) void'(sb[k].pop_front());
         end
         if (in_valid && exp_ready) sb[in_sel].push_back(in_data);
      end
   end

   initial begin
      logic hold;
      rst = 1'b1; in_valid = 1'b0; in_sel = 2'd0; in_data = '0; out_ready = 4'h0;
      step(); step();
      chk("reset_out_valid", 32'(out_valid), 32'h0);
      chk("reset_busy", 32'(busy), 32'h0);
      chk("reset_data0", out_data0, 32'h0);
      chk("reset_data3", out_data3, 32'h0);
      rst = 1'b0;
      step();

      // Single route to channel 2.
      in_sel = 2'd2; in_data = 32'hDEADBEEF; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      chk("single_out_valid", 32'(out_valid), 32'h4);
      chk("single_data2", out_data2, 32'hDEADBEEF);
      chk("single_busy", 32'(busy), 32'h1);
      out_ready = 4'b0100;
      step();
      out_ready = 4'h0;
      chk("single_drained", 32'(out_valid), 32'h0);

      // Backpressure on channel 1.
      in_sel = 2'd1; in_data = 32'hA1; in_valid = 1'b1;
      step();
      in_data = 32'hB2;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("bp_in_ready_low", 32'(in_ready), 32'h0);
         chk("bp_data1_held", out_data1, 32'hA1);
         step();
      end
      out_ready = 4'b0010;
      #1;
      chk("bp_in_ready_high", 32'(in_ready), 32'h1);
      step();
      in_valid = 1'b0; out_ready = 4'h0;
      chk("bp_vld1", 32'(out_valid[1]), 32'h1);
      chk("bp_data1_new", out_data1, 32'hB2);
      out_ready = 4'b0010;
      step();
      out_ready = 4'h0;

      // Streaming into channel 3.
      in_sel = 2'd3; out_ready = 4'b1000;
      for (int i = 1; i <= 8; i++) begin
         in_data = 32'(i); in_valid = 1'b1;
         #1;
         chk("stream_in_ready", 32'(in_ready), 32'h1);
         step();
         chk("stream_data3", out_data3, 32'(i));
         chk("stream_vld3", 32'(out_valid), 32'h8);
      end
      in_valid = 1'b0;
      step();
      out_ready = 4'h0;
      chk("stream_empty", 32'(out_valid), 32'h0);

      // Independence: channel 0 stalled, accept to channel 2 while channel 0 drains.
      in_sel = 2'd0; in_data = 32'h77; in_valid = 1'b1;
      step();
      in_sel = 2'd2; in_data = 32'h5; out_ready = 4'b0001;
      #1;
      chk("indep_in_ready", 32'(in_ready), 32'h1);
      step();
      in_valid = 1'b0; out_ready = 4'h0;
      chk("indep_out_valid", 32'(out_valid), 32'h4);
      chk("indep_data2", out_data2, 32'h5);
      out_ready = 4'b0100;
      step();
      out_ready = 4'h0;

      // Asynchronous reset with channels 0, 1, 3 full.
      in_valid = 1'b1;
      in_sel = 2'd0; in_data = 32'h10; step();
      in_sel = 2'd1; in_data = 32'h11; step();
      in_sel = 2'd3; in_data = 32'h13; step();
      in_valid = 1'b0;
      chk("prerst_out_valid", 32'(out_valid), 32'hB);
      #2 rst = 1'b1;
      #1;
      chk("arst_out_valid", 32'(out_valid), 32'h0);
      chk("arst_busy", 32'(busy), 32'h0);
      chk("arst_data0", out_data0, 32'h0);
      chk("arst_data1", out_data1, 32'h0);
      chk("arst_data3", out_data3, 32'h0);
      step();
      rst = 1'b0;
      step();

      // Random traffic; producer holds its word until accepted.
      hold = 1'b0;
      for (int i = 0; i < 10000; i++) begin
         if (!hold) begin
            in_valid = 1'($urandom_range(0, 1));
            in_sel   = 2'($urandom_range(0, 3));
            in_data  = $urandom;
         end
         out_ready = 4'($urandom_range(0, 15));
         @(negedge clk);
         hold = in_valid & ~in_ready;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0; out_ready = 4'hF;
      step(); step();
      chk("final_out_valid", 32'(out_valid), 32'h0);
      chk("final_busy", 32'(busy), 32'h0);
      for (int k = 0; k < 4; k++) chk("final_sb_empty", 32'(sb[k].size()), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule
